align_shift_sequencer: RTL and testbench

Multi-cycle alignment controller for the minifloat adder datapath. It owns the shared 8-bit logical-right barrel shifter, which has a 3-bit shift amount. For each accepted operand pair it picks the smaller-exponent mantissa and drives the shifter repeatedly, at most 7 positions per cycle, until the full exponent difference is applied. It accumulates a sticky bit and presents the aligned mantissas with the common exponent through a valid/ready handshake.

---
 rtl/align_shift_sequencer.sv | 131 +++++++++++++
 tb/tb_align_shift_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/align_shift_sequencer.sv
// Alignment controller for the minifloat adder: picks the smaller-exponent mantissa and
// walks it through the shared 3-bit barrel shifter until the exponent gap is consumed.
module align_shift_sequencer #(
    parameter int unsigned EXP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic [7:0]       man_a,
    input  logic [7:0]       man_b,
    output logic [7:0]       sh_inp,
    output logic [2:0]       sh_diff,
    input  logic [7:0]       sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_exp,
    output logic [7:0]       out_big,
    output logic [7:0]       out_small,
    output logic             out_sticky,
    output logic             out_swapped
);

    localparam int unsigned MAN_W    = 8;
    localparam int unsigned MAX_STEP = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [EXP_W-1:0]   rem, rem_d, rem_left, abs_diff, exp_d;
    logic [MAN_W-1:0]   big_d, cur_d, sh_inp_d, mask;
    logic [2:0]         step, sh_diff_d;
    logic               sticky_d, swapped_d, in_ready_d, out_valid_d;

    // Per-cycle shift amount: the remaining gap, capped at the shifter's reach.
    function automatic logic [2:0] step_of(input logic [EXP_W-1:0] r);
        return (int'(r) > int'(MAX_STEP)) ? 3'(MAX_STEP) : 3'(r);
    endfunction

    always_comb begin
        state_d   = state;
        rem_d     = rem;
        exp_d     = out_exp;
        big_d     = out_big;
        cur_d     = out_small;
        sticky_d  = out_sticky;
        swapped_d = out_swapped;

        // sh_diff already holds min(rem,7) during SHIFT, so it doubles as the step.
        step     = sh_diff;
        mask     = MAN_W'((9'd1 << step) - 9'd1);
        rem_left = rem - EXP_W'(step);
        abs_diff = (exp_a >= exp_b) ? (exp_a - exp_b) : (exp_b - exp_a);

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (exp_a >= exp_b) begin
                        big_d     = man_a;
                        cur_d     = man_b;
                        swapped_d = 1'b0;
                        exp_d     = exp_a;
                    end else begin
                        big_d     = man_b;
                        cur_d     = man_a;
                        swapped_d = 1'b1;
                        exp_d     = exp_b;
                    end
                    rem_d    = abs_diff;
                    sticky_d = 1'b0;
                    state_d  = ((abs_diff == '0) || (cur_d == '0)) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                cur_d    = sh_result;
                sticky_d = out_sticky | (|(out_small & mask));
                rem_d    = rem_left;
                if ((rem_left == '0) || (sh_result == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake and shifter drive are registered from the next-state decode.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        sh_inp_d    = (state_d == SHIFT) ? cur_d : '0;
        sh_diff_d   = (state_d == SHIFT) ? step_of(rem_d) : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_exp     <= '0;
            out_big     <= '0;
            out_small   <= '0;
            out_sticky  <= 1'b0;
            out_swapped <= 1'b0;
            sh_inp      <= '0;
            sh_diff     <= 3'd0;
        end else begin
            state       <= state_d;
            rem         <= rem_d;
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
            out_exp     <= exp_d;
            out_big     <= big_d;
            out_small   <= cur_d;
            out_sticky  <= sticky_d;
            out_swapped <= swapped_d;
            sh_inp      <= sh_inp_d;
            sh_diff     <= sh_diff_d;
        end
    end

endmodule

// File: tb/tb_align_shift_sequencer.sv
// Directed bench for align_shift_sequencer with a behavioural model of the shared shifter.
module tb_align_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [3:0] exp_a, exp_b;
    logic [7:0] man_a, man_b;
    logic [7:0] sh_inp, sh_result;
    logic [2:0] sh_diff;
    logic       out_valid, out_ready;
    logic [3:0] out_exp;
    logic [7:0] out_big, out_small;
    logic       out_sticky, out_swapped;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sh_result = sh_inp >> sh_diff;

    align_shift_sequencer #(.EXP_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .exp_a(exp_a), .exp_b(exp_b), .man_a(man_a), .man_b(man_b),
        .sh_inp(sh_inp), .sh_diff(sh_diff), .sh_result(sh_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exp(out_exp), .out_big(out_big), .out_small(out_small),
        .out_sticky(out_sticky), .out_swapped(out_swapped)
    );

    // Result bundle: {valid, exp, big, small, sticky, swapped}
    function automatic logic [22:0] res();
        return {out_valid, out_exp, out_big, out_small, out_sticky, out_swapped};
    endfunction

    task automatic drive(input logic [3:0] ea, input logic [7:0] ma,
                         input logic [3:0] eb, input logic [7:0] mb);
        exp_a = ea; man_a = ma; exp_b = eb; man_b = mb; in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        exp_a = '0; exp_b = '0; man_a = '0; man_b = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++;
        if ({res(), in_ready, sh_inp, sh_diff} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state got %h expected 0", {res(), in_ready, sh_inp, sh_diff});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release got %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_equal();
        @(negedge clk);
        drive(4'd6, 8'h9C, 4'd6, 8'h41);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL equal_ready got %b expected 1", in_ready); end
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if ({res(), sh_diff} !== {1'b1, 4'd6, 8'h9C, 8'h41, 1'b0, 1'b0, 3'd0}) begin
            errors++; $display("FAIL equal_result got %h expected %h", {res(), sh_diff},
                               {1'b1, 4'd6, 8'h9C, 8'h41, 1'b0, 1'b0, 3'd0});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL equal_return got %b expected 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_single_step();
        @(negedge clk); drive(4'd5, 8'hB4, 4'd3, 8'h96);
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready, sh_inp, sh_diff} !== {1'b0, 1'b0, 8'h96, 3'd2}) begin
            errors++; $display("FAIL single_shift got %h expected %h",
                               {out_valid, in_ready, sh_inp, sh_diff}, {1'b0, 1'b0, 8'h96, 3'd2});
        end
        @(negedge clk);
        checks++;
        if (res() !== {1'b1, 4'd5, 8'hB4, 8'h25, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_result got %h expected %h", res(),
                               {1'b1, 4'd5, 8'hB4, 8'h25, 1'b1, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_swap_multi();
        @(negedge clk); drive(4'd2, 8'h81, 4'd12, 8'hC0);
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if ({out_valid, sh_inp, sh_diff} !== {1'b0, 8'h81, 3'd7}) begin
            errors++; $display("FAIL swap_shift1 got %h expected %h", {out_valid, sh_inp, sh_diff},
                               {1'b0, 8'h81, 3'd7});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, sh_inp, sh_diff} !== {1'b0, 8'h01, 3'd3}) begin
            errors++; $display("FAIL swap_shift2 got %h expected %h", {out_valid, sh_inp, sh_diff},
                               {1'b0, 8'h01, 3'd3});
        end
        @(negedge clk);
        checks++;
        if ({res(), sh_diff} !== {1'b1, 4'd12, 8'hC0, 8'h00, 1'b1, 1'b1, 3'd0}) begin
            errors++; $display("FAIL swap_result got %h expected %h", {res(), sh_diff},
                               {1'b1, 4'd12, 8'hC0, 8'h00, 1'b1, 1'b1, 3'd0});
        end
        @(negedge clk);
    endtask

    task automatic test_early_term();
        @(negedge clk); drive(4'd15, 8'h10, 4'd0, 8'hFF);
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if ({out_valid, sh_inp, sh_diff} !== {1'b0, 8'hFF, 3'd7}) begin
            errors++; $display("FAIL early_shift1 got %h expected %h", {out_valid, sh_inp, sh_diff},
                               {1'b0, 8'hFF, 3'd7});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, sh_inp, sh_diff} !== {1'b0, 8'h01, 3'd7}) begin
            errors++; $display("FAIL early_shift2 got %h expected %h", {out_valid, sh_inp, sh_diff},
                               {1'b0, 8'h01, 3'd7});
        end
        @(negedge clk);
        checks++;
        if (res() !== {1'b1, 4'd15, 8'h10, 8'h00, 1'b1, 1'b0}) begin
            errors++; $display("FAIL early_result got %h expected %h", res(),
                               {1'b1, 4'd15, 8'h10, 8'h00, 1'b1, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        @(negedge clk); drive(4'd9, 8'h5A, 4'd9, 8'h33);
        @(negedge clk); drive(4'd4, 8'h80, 4'd2, 8'h0C);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({res(), in_ready} !== {1'b1, 4'd9, 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0}) begin
                errors++; $display("FAIL bp_hold[%0d] got %h expected %h", i, {res(), in_ready},
                                   {1'b1, 4'd9, 8'h5A, 8'h33, 1'b0, 1'b0, 1'b0});
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, sh_diff} !== {1'b0, 1'b1, 3'd0}) begin
            errors++; $display("FAIL bp_release got %h expected %h", {out_valid, in_ready, sh_diff},
                               {1'b0, 1'b1, 3'd0});
        end
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if ({out_valid, sh_inp, sh_diff} !== {1'b0, 8'h0C, 3'd2}) begin
            errors++; $display("FAIL bp_next_shift got %h expected %h", {out_valid, sh_inp, sh_diff},
                               {1'b0, 8'h0C, 3'd2});
        end
        @(negedge clk);
        checks++;
        if (res() !== {1'b1, 4'd4, 8'h80, 8'h03, 1'b0, 1'b0}) begin
            errors++; $display("FAIL bp_next_result got %h expected %h", res(),
                               {1'b1, 4'd4, 8'h80, 8'h03, 1'b0, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk); drive(4'd2, 8'h81, 4'd12, 8'hC0);
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if (sh_diff !== 3'd7) begin errors++; $display("FAIL rst_mid_shift got %0d expected 7", sh_diff); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({res(), in_ready, sh_inp, sh_diff} !== 35'd0) begin
            errors++; $display("FAIL rst_mid_clear got %h expected 0", {res(), in_ready, sh_inp, sh_diff});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL rst_mid_release got %b expected 10", {in_ready, out_valid});
        end
        drive(4'd3, 8'h7E, 4'd3, 8'h18);
        @(negedge clk); in_valid = 1'b0;
        checks++;
        if (res() !== {1'b1, 4'd3, 8'h7E, 8'h18, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rst_mid_fresh got %h expected %h", res(),
                               {1'b1, 4'd3, 8'h7E, 8'h18, 1'b0, 1'b0});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_equal();
        test_single_step();
        test_swap_multi();
        test_early_term();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
